// File: rtl/ts_multi_timer.sv
// Multi-channel countdown timer driven by a shared divide-by-DIV prescaler tick.
// Optional auto-reload of periodic channels is enabled by defining TS_MULTI_TIMER_RELOAD_EN.
module ts_multi_timer #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DIV      = 1000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*CNT_W-1:0] load_val,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS-1:0]       ack,
  input  logic [CHANNELS-1:0]       periodic,
  output logic                      tick,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS*CNT_W-1:0] remaining
);

  localparam int unsigned   PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [PW-1:0]                  pre_cnt_q, pre_cnt_d;
  state_e                         state_q [CHANNELS];
  state_e                         state_d [CHANNELS];
  logic [CHANNELS-1:0][CNT_W-1:0] rem_q, rem_d;
  logic [CHANNELS-1:0]            done_q, done_d;
  logic [CHANNELS-1:0]            expired_q, expired_d;

`ifdef TS_MULTI_TIMER_RELOAD_EN
  logic [CHANNELS-1:0][CNT_W-1:0] cap_load_q, cap_load_d;
  logic [CHANNELS-1:0]            cap_per_q, cap_per_d;
`else
  logic unused_periodic;
  assign unused_periodic = ^periodic;
`endif

  assign tick = (pre_cnt_q == PRE_MAX);

  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_MAX) ? '0 : pre_cnt_q + 1'b1;
  end

  // Priority per channel: cancel, then start, then tick-driven countdown.
  always_comb begin
    rem_d     = rem_q;
    done_d    = '0;
    expired_d = expired_q;
`ifdef TS_MULTI_TIMER_RELOAD_EN
    cap_load_d = cap_load_q;
    cap_per_d  = cap_per_q;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (cancel[i]) begin
        state_d[i] = IDLE;
        rem_d[i]   = '0;
      end else if (start[i]) begin
        rem_d[i] = load_val[i*CNT_W +: CNT_W];
`ifdef TS_MULTI_TIMER_RELOAD_EN
        cap_load_d[i] = load_val[i*CNT_W +: CNT_W];
        cap_per_d[i]  = periodic[i];
`endif
        if (load_val[i*CNT_W +: CNT_W] == '0) begin
          state_d[i] = IDLE;
          done_d[i]  = 1'b1;
        end else begin
          state_d[i] = RUN;
        end
      end else if ((state_q[i] == RUN) && tick) begin
        if (rem_q[i] == CNT_W'(1)) begin
          done_d[i] = 1'b1;
`ifdef TS_MULTI_TIMER_RELOAD_EN
          if (cap_per_q[i] && (cap_load_q[i] != '0)) begin
            rem_d[i] = cap_load_q[i];
          end else begin
            state_d[i] = IDLE;
            rem_d[i]   = '0;
          end
`else
          state_d[i] = IDLE;
          rem_d[i]   = '0;
`endif
        end else begin
          rem_d[i] = rem_q[i] - 1'b1;
        end
      end
      // A fresh expiry outranks a simultaneous acknowledge.
      expired_d[i] = done_d[i] | (expired_q[i] & ~ack[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      rem_q     <= '0;
      done_q    <= '0;
      expired_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
      end
`ifdef TS_MULTI_TIMER_RELOAD_EN
      cap_load_q <= '0;
      cap_per_q  <= '0;
`endif
    end else begin
      pre_cnt_q <= pre_cnt_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      expired_q <= expired_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
`ifdef TS_MULTI_TIMER_RELOAD_EN
      cap_load_q <= cap_load_d;
      cap_per_q  <= cap_per_d;
`endif
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      busy[i] = (state_q[i] == RUN);
    end
  end

  assign done      = done_q;
  assign expired   = expired_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_ts_multi_timer.sv
// Bench for ts_multi_timer: directed scenarios plus random traffic against a
// deadline-based behavioural model (expiry cycle computed from the tick schedule).
`timescale 1ns/1ps
module tb_ts_multi_timer;

  localparam int CH  = 2;
  localparam int CW  = 8;
  localparam int DIV = 4;

  logic            clock;
  logic            reset_n;
  logic [CH-1:0]   start;
  logic [CH*CW-1:0] load_val;
  logic [CH-1:0]   cancel;
  logic [CH-1:0]   ack;
  logic [CH-1:0]   periodic;
  logic            tick;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   done;
  logic [CH-1:0]   expired;
  logic [CH*CW-1:0] remaining;

  ts_multi_timer #(
    .CHANNELS (CH),
    .CNT_W    (CW),
    .DIV      (DIV)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .load_val  (load_val),
    .cancel    (cancel),
    .ack       (ack),
    .periodic  (periodic),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .expired   (expired),
    .remaining (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int t;

  // Model: per channel, whether it is counting, when it was (re)loaded, with
  // what count, and the cycle of the tick on which it must expire.
  bit m_active [CH];
  int m_s      [CH];
  int m_n      [CH];
  int m_exp    [CH];
  bit m_per    [CH];
  bit m_done   [CH];
  bit m_expd   [CH];

  // Per-phase observations of the DUT, for literal pins.
  logic [63:0] ob_tick, ob_done0, ob_done1, ob_busy0, ob_busy1, ob_exp0;
  int          ob_rem0 [64];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp);
    end
  endtask

  function automatic int ticks_in(input int a, input int b);
    if (b < a) return 0;
    return (b + 1) / DIV - a / DIV;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < CH; c++) begin
      m_active[c] = 0; m_s[c] = 0; m_n[c] = 0; m_exp[c] = 0;
      m_per[c] = 0; m_done[c] = 0; m_expd[c] = 0;
    end
    ob_tick = '0; ob_done0 = '0; ob_done1 = '0;
    ob_busy0 = '0; ob_busy1 = '0; ob_exp0 = '0;
    for (int k = 0; k < 64; k++) ob_rem0[k] = -1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " tick"}, int'(tick), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " expired"}, int'(expired), 0);
    chk({tag, " remaining"}, int'(remaining), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    start = '0; load_val = '0; cancel = '0; ack = '0; periodic = '0;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(negedge clock);
    check_all_zero("reset_hold");
    reset_n = 1'b1;
    t = 0;
    clear_model();
  endtask

  task automatic step(input logic [1:0] st, input logic [7:0] l0, input logic [7:0] l1,
                      input logic [1:0] cn, input logic [1:0] ak, input logic [1:0] pr);
    chk("tick", int'(tick), ((t % DIV) == DIV - 1) ? 1 : 0);
    for (int c = 0; c < CH; c++) begin
      int exp_rem;
      exp_rem = m_active[c] ? (m_n[c] - ticks_in(m_s[c] + 1, t - 1)) : 0;
      chk($sformatf("busy[%0d]", c), int'(busy[c]), int'(m_active[c]));
      chk($sformatf("done[%0d]", c), int'(done[c]), int'(m_done[c]));
      chk($sformatf("expired[%0d]", c), int'(expired[c]), int'(m_expd[c]));
      chk($sformatf("remaining[%0d]", c), int'(remaining[c*CW +: CW]), exp_rem);
    end
    if (t < 64) begin
      ob_tick[t]  = tick;
      ob_done0[t] = done[0];
      ob_done1[t] = done[1];
      ob_busy0[t] = busy[0];
      ob_busy1[t] = busy[1];
      ob_exp0[t]  = expired[0];
      ob_rem0[t]  = int'(remaining[CW-1:0]);
    end

    start = st; load_val = {l1, l0}; cancel = cn; ack = ak; periodic = pr;

    for (int c = 0; c < CH; c++) begin
      int ld;
      bit nd;
      ld = (c == 0) ? int'(l0) : int'(l1);
      nd = 0;
      if (cn[c]) begin
        m_active[c] = 0;
      end else if (st[c]) begin
        m_per[c] = pr[c];
        if (ld == 0) begin
          nd = 1;
          m_active[c] = 0;
        end else begin
          m_active[c] = 1;
          m_s[c] = t;
          m_n[c] = ld;
          m_exp[c] = ((t + 1) / DIV + ld) * DIV - 1;
        end
      end else if (m_active[c] && (t == m_exp[c])) begin
        nd = 1;
`ifdef TS_MULTI_TIMER_RELOAD_EN
        if (m_per[c]) begin
          m_s[c] = t;
          m_exp[c] = t + m_n[c] * DIV;
        end else begin
          m_active[c] = 0;
        end
`else
        m_active[c] = 0;
`endif
      end
      m_expd[c] = nd || (m_expd[c] && !ak[c]);
      m_done[c] = nd;
    end

    @(negedge clock);
    t++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0d actual=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    start = '0; load_val = '0; cancel = '0; ack = '0; periodic = '0;
    t = 0;
    clear_model();

    // Prescaler only
    do_reset();
    idle(12);
    chk("pin tick cycles", int'(ob_tick[11:0]), 'h888);
    chk("pin idle busy", int'(ob_busy0[11:0] | ob_busy1[11:0]), 0);

    // One-shot of 2 units started in cycle 1, ack in cycle 10
    do_reset();
    idle(1);
    step(2'b01, 8'd2, 8'd0, 2'b00, 2'b00, 2'b00);
    idle(8);
    step(2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00);
    idle(5);
    chk("pin oneshot done0", int'(ob_done0[15:0]), 'h0100);
    chk("pin oneshot busy0", int'(ob_busy0[15:0]), 'h00FC);
    chk("pin oneshot expired0", int'(ob_exp0[15:0]), 'h0700);
    chk("pin oneshot rem t2", ob_rem0[2], 2);
    chk("pin oneshot rem t3", ob_rem0[3], 2);
    chk("pin oneshot rem t4", ob_rem0[4], 1);

    // Zero load on ch1, start+cancel on ch0
    do_reset();
    idle(1);
    step(2'b10, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00);
    step(2'b01, 8'd5, 8'd0, 2'b01, 2'b00, 2'b00);
    idle(10);
    chk("pin zero done1", int'(ob_done1[12:0]), 'h0004);
    chk("pin zero busy1", int'(ob_busy1[12:0]), 0);
    chk("pin cancel-wins busy0", int'(ob_busy0[12:0]), 0);

    // Cancel mid-count
    do_reset();
    idle(1);
    step(2'b01, 8'd3, 8'd0, 2'b00, 2'b00, 2'b00);
    idle(3);
    step(2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
    idle(14);
    chk("pin cancel done0", int'(ob_done0[19:0]), 0);
    chk("pin cancel rem t5", ob_rem0[5], 2);
    chk("pin cancel rem t6", ob_rem0[6], 0);

    // Restart mid-count with 1
    do_reset();
    idle(1);
    step(2'b01, 8'd3, 8'd0, 2'b00, 2'b00, 2'b00);
    idle(3);
    step(2'b01, 8'd1, 8'd0, 2'b00, 2'b00, 2'b00);
    idle(8);
    chk("pin restart done0", int'(ob_done0[13:0]), 'h0100);

    // Ack held across expiry and the done cycle
    do_reset();
    idle(1);
    step(2'b01, 8'd2, 8'd0, 2'b00, 2'b00, 2'b00);
    idle(5);
    step(2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00);
    step(2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00);
    idle(3);
    chk("pin ackrace expired0", int'(ob_exp0[11:0]), 'h0100);
    chk("pin ackrace done0", int'(ob_done0[11:0]), 'h0100);

    // Periodic request on a 1-unit load, cancelled in cycle 14
    do_reset();
    idle(1);
    step(2'b01, 8'd1, 8'd0, 2'b00, 2'b00, 2'b01);
    idle(12);
    step(2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 2'b00);
    idle(8);
`ifdef TS_MULTI_TIMER_RELOAD_EN
    chk("pin periodic done0", int'(ob_done0[22:0]), 'h1110);
`else
    chk("pin periodic done0", int'(ob_done0[22:0]), 'h0010);
`endif

    // Random traffic
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      logic [1:0] st, cn, ak, pr;
      logic [7:0] l [2];
      for (int c = 0; c < CH; c++) begin
        st[c] = ($urandom_range(0, 11) == 0);
        cn[c] = ($urandom_range(0, 39) == 0);
        ak[c] = ($urandom_range(0, 7) == 0);
        pr[c] = $urandom_range(0, 1);
        case ($urandom_range(0, 15))
          0:       l[c] = 8'd0;
          1:       l[c] = 8'($urandom_range(20, 255));
          default: l[c] = 8'($urandom_range(1, 6));
        endcase
      end
      step(st, l[0], l[1], cn, ak, pr);
    end

    // Reset mid-count, then confirm nothing leaks out afterwards
    step(2'b11, 8'd5, 8'd7, 2'b00, 2'b00, 2'b00);
    idle(6);
    do_reset();
    idle(40);
    chk("pin post-reset done", int'(ob_done0[39:0] | ob_done1[39:0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
